latch_wr_arbiter: RTL and testbench

LATCH_WR_ARBITER -- requirements
Module: latch_wr_arbiter

---
 rtl/latch_wr_arbiter_if.sv | 30 +++
 rtl/latch_wr_arbiter.sv | 158 +++++++++++++++
 tb/tb_latch_wr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/latch_wr_arbiter_if.sv
// Bus between the write arbiter and its requesters / latch bank.
// The arbiter sits on the slave side; the requester environment drives the master side.
interface latch_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 8
);
  localparam int unsigned NE = 2**AW;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ*AW-1:0] waddr;
  logic               clr_req;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      lat_d;
  logic [NE-1:0]      lat_en;
  logic [NE-1:0]      lat_rst;
  logic               busy;
  logic               clr_done;

  modport master (
    output req, wdata, waddr, clr_req,
    input  ack, lat_d, lat_en, lat_rst, busy, clr_done
  );

  modport slave (
    input  req, wdata, waddr, clr_req,
    output ack, lat_d, lat_en, lat_rst, busy, clr_done
  );
endinterface

// File: rtl/latch_wr_arbiter.sv
// Round-robin write arbiter driving a bank of 2**AW reset-able D latches with a
// glitch-free SETUP/PULSE/HOLD write sequence and a one-entry-per-cycle clear sweep.
module latch_wr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  latch_wr_arbiter_if.slave  bus
);
  localparam int unsigned NE = 2**AW;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [IW-1:0]  r_last;
  logic [IW-1:0]  r_winner;
  logic [AW-1:0]  r_addr;
  logic [AW-1:0]  r_cnt;
  logic [AW-1:0]  w_cnt_nxt;
  logic           r_clr_pend;
  logic           w_clr_go;
  logic           w_found;
  logic [IW-1:0]  w_grant;

  logic [NREQ-1:0] r_ack,      w_ack_nxt;
  logic [DW-1:0]   r_lat_d,    w_lat_d_nxt;
  logic [NE-1:0]   r_lat_en,   w_lat_en_nxt;
  logic [NE-1:0]   r_lat_rst,  w_lat_rst_nxt;
  logic            r_busy,     w_busy_nxt;
  logic            r_clr_done, w_clr_done_nxt;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] last, input int unsigned k);
    int unsigned s;
    s = (32'(last) + 32'd1 + k) % NREQ;
    return IW'(s);
  endfunction

  // First requesting index at or after last_winner+1, wrapping
  always_comb begin
    w_found = 1'b0;
    w_grant = r_last;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req[rr_idx(r_last, k)]) begin
        w_found = 1'b1;
        w_grant = rr_idx(r_last, k);
      end
    end
  end

  assign w_clr_go  = bus.clr_req | r_clr_pend;
  assign w_cnt_nxt = (r_state == S_CLEAR) ? r_cnt + AW'(1) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A pending clear outranks any write request in IDLE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_clr_go)     w_state_nxt = S_CLEAR;
        else if (w_found) w_state_nxt = S_SETUP;
      end
      S_SETUP: w_state_nxt = S_PULSE;
      S_PULSE: w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_IDLE;
      S_CLEAR: if (&r_cnt) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next output values keyed on the state being entered, so every output is a flop
  always_comb begin
    w_lat_d_nxt    = r_lat_d;
    w_lat_en_nxt   = '0;
    w_lat_rst_nxt  = '0;
    w_ack_nxt      = '0;
    w_clr_done_nxt = 1'b0;
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    unique case (w_state_nxt)
      S_SETUP: w_lat_d_nxt    = bus.wdata[w_grant*DW +: DW];
      S_PULSE: w_lat_en_nxt   = NE'(1) << r_addr;
      S_HOLD:  w_ack_nxt      = NREQ'(1) << r_winner;
      S_CLEAR: w_lat_rst_nxt  = NE'(1) << w_cnt_nxt;
      S_IDLE:  w_clr_done_nxt = (r_state == S_CLEAR);
      default: w_busy_nxt     = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lat_d    <= '0;
      r_lat_en   <= '0;
      r_lat_rst  <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_lat_d    <= w_lat_d_nxt;
      r_lat_en   <= w_lat_en_nxt;
      r_lat_rst  <= w_lat_rst_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= w_busy_nxt;
      r_clr_done <= w_clr_done_nxt;
    end
  end

  // Transaction capture, round-robin pointer, sweep counter and deferred clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last     <= LAST_INIT;
      r_winner   <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_clr_pend <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (r_state == S_IDLE && w_state_nxt == S_SETUP) begin
        r_winner <= w_grant;
        r_addr   <= bus.waddr[w_grant*AW +: AW];
      end
      if (r_state == S_HOLD) r_last <= r_winner;
      if (r_state == S_IDLE && w_state_nxt == S_CLEAR) begin
        r_clr_pend <= 1'b0;
      end else if (bus.clr_req &&
                   (r_state == S_SETUP || r_state == S_PULSE || r_state == S_HOLD)) begin
        r_clr_pend <= 1'b1;
      end
    end
  end

  assign bus.ack      = r_ack;
  assign bus.lat_d    = r_lat_d;
  assign bus.lat_en   = r_lat_en;
  assign bus.lat_rst  = r_lat_rst;
  assign bus.busy     = r_busy;
  assign bus.clr_done = r_clr_done;

  // Latch-bank safety: single enable, never enable and reset together, single ack
  a_en_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(r_lat_en));
  a_ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(r_ack));
  a_en_rst_excl: assert property (@(posedge clk) disable iff (reset)
                                  !((|r_lat_en) && (|r_lat_rst)));
endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Bench for latch_wr_arbiter: schedule-based reference model compared every cycle,
// directed scenarios with literal expectations, and an attached latch bank.
module tb_latch_wr_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned NE   = 2**AW;
  localparam int RING = 32;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  latch_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  latch_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset-able D latch bank on the arbiter's outputs
  wire [NE*DW-1:0] w_mem;
  for (genvar k = 0; k < NE; k++) begin : g_lat
    logic [DW-1:0] q;
    always_latch begin
      if (bus.lat_rst[k])     q <= '0;
      else if (bus.lat_en[k]) q <= bus.lat_d;
    end
    assign w_mem[k*DW +: DW] = q;
  end

  function automatic logic [DW-1:0] entry(input int e);
    return w_mem[e*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted operation books its output pattern into future cycles
  int              cyc;
  int              free_at;
  int              m_last;
  bit              m_pend;
  bit              m_clear_op;
  logic [NE-1:0]   s_en   [RING];
  logic [NE-1:0]   s_rst  [RING];
  logic [NREQ-1:0] s_ack  [RING];
  bit              s_busy [RING];
  bit              s_done [RING];
  logic [DW-1:0]   e_d;
  logic [NE-1:0]   e_en, e_rst;
  logic [NREQ-1:0] e_ack;
  logic            e_busy, e_done;

  task automatic model_reset();
    cyc = 0; free_at = 0; m_last = NREQ - 1; m_pend = 1'b0; m_clear_op = 1'b0;
    for (int i = 0; i < RING; i++) begin
      s_en[i] = '0; s_rst[i] = '0; s_ack[i] = '0; s_busy[i] = 1'b0; s_done[i] = 1'b0;
    end
    e_d = '0; e_en = '0; e_rst = '0; e_ack = '0; e_busy = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_edge();
    int n;
    int w;
    int a;
    cyc++;
    n = cyc;
    if (n - 1 >= free_at) begin
      if (bus.clr_req || m_pend) begin
        m_pend = 1'b0; m_clear_op = 1'b1;
        for (int k = 0; k < int'(NE); k++) begin
          s_rst[(n + k) % RING]  = NE'(1) << k;
          s_busy[(n + k) % RING] = 1'b1;
        end
        s_done[(n + int'(NE)) % RING] = 1'b1;
        free_at = n + int'(NE);
      end else if (bus.req != '0) begin
        w = -1;
        for (int k = 1; k <= int'(NREQ); k++)
          if (w < 0 && bus.req[(m_last + k) % int'(NREQ)]) w = (m_last + k) % int'(NREQ);
        a = int'(bus.waddr[w*AW +: AW]);
        e_d = bus.wdata[w*DW +: DW];
        s_en[(n + 1) % RING]  = NE'(1) << a;
        s_ack[(n + 2) % RING] = NREQ'(1) << w;
        for (int k = 0; k < 3; k++) s_busy[(n + k) % RING] = 1'b1;
        free_at = n + 3; m_last = w; m_clear_op = 1'b0;
      end
    end else if (!m_clear_op && bus.clr_req) begin
      m_pend = 1'b1;
    end
    e_en   = s_en[n % RING];   s_en[n % RING]   = '0;
    e_rst  = s_rst[n % RING];  s_rst[n % RING]  = '0;
    e_ack  = s_ack[n % RING];  s_ack[n % RING]  = '0;
    e_busy = s_busy[n % RING]; s_busy[n % RING] = 1'b0;
    e_done = s_done[n % RING]; s_done[n % RING] = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_edge();
    end
  end

  // Every-cycle comparison against the model
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cmp_lat_d",    32'(bus.lat_d),    32'(e_d));
      chk("cmp_lat_en",   32'(bus.lat_en),   32'(e_en));
      chk("cmp_lat_rst",  32'(bus.lat_rst),  32'(e_rst));
      chk("cmp_ack",      32'(bus.ack),      32'(e_ack));
      chk("cmp_busy",     32'(bus.busy),     32'(e_busy));
      chk("cmp_clr_done", 32'(bus.clr_done), 32'(e_done));
    end
  end

  task automatic wait_ack(input string name, input int max, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.ack == '0 && waited < max);
    chk(name, 32'(bus.ack != '0), 32'd1);
  endtask

  initial begin
    int nack;
    int waited;
    int first_rst, done_c, ack_c, cnt;
    logic [NREQ-1:0] ack_vec [5];
    int              ack_cyc [5];

    reset = 1'b1;
    bus.req = '0; bus.wdata = '0; bus.waddr = '0; bus.clr_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_lat_en", 32'(bus.lat_en), 32'h0);
    chk("rst_lat_rst", 32'(bus.lat_rst), 32'h0);
    chk("rst_lat_d", 32'(bus.lat_d), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_clr_done", 32'(bus.clr_done), 32'h0);
    reset = 1'b0;

    // Single write: requester 0, data A5 to entry 3
    @(negedge clk);
    bus.req = 4'b0001; bus.wdata[0 +: DW] = 8'hA5; bus.waddr[0 +: AW] = 3'd3;
    @(negedge clk);
    chk("t1_setup_d", 32'(bus.lat_d), 32'hA5);
    chk("t1_setup_en", 32'(bus.lat_en), 32'h0);
    @(negedge clk);
    chk("t1_pulse_en", 32'(bus.lat_en), 32'h08);
    @(negedge clk);
    chk("t1_hold_ack", 32'(bus.ack), 32'h1);
    chk("t1_hold_en", 32'(bus.lat_en), 32'h0);
    bus.req = '0;
    @(negedge clk);
    chk("t1_mem3", 32'(entry(3)), 32'hA5);

    // All four requesting continuously after a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b1111;
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.waddr = {3'd7, 3'd6, 3'd5, 3'd4};
    nack = 0;
    for (int c = 0; c < 40 && nack < 5; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        ack_vec[nack] = bus.ack; ack_cyc[nack] = c; nack++;
        if (nack == 5) bus.req = '0;
      end
    end
    chk("t2_nacks", 32'(nack), 32'd5);
    for (int k = 0; k < nack; k++) begin
      chk("t2_order", 32'(ack_vec[k]), 32'(NREQ'(1) << (k % 4)));
      if (k > 0) chk("t2_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
    end
    @(negedge clk);
    chk("t2_mem4", 32'(entry(4)), 32'h11);
    chk("t2_mem5", 32'(entry(5)), 32'h22);
    chk("t2_mem6", 32'(entry(6)), 32'h33);
    chk("t2_mem7", 32'(entry(7)), 32'h44);

    // Clear and write requested together: sweep first, then the write
    bus.clr_req = 1'b1; bus.req = 4'b0010;
    bus.wdata[8 +: DW] = 8'h5A; bus.waddr[3 +: AW] = 3'd2;
    for (int k = 0; k < int'(NE); k++) begin
      @(negedge clk);
      bus.clr_req = 1'b0;
      chk("t3_walk", 32'(bus.lat_rst), 32'(NE'(1) << k));
      chk("t3_walk_en", 32'(bus.lat_en), 32'h0);
    end
    @(negedge clk);
    chk("t3_done", 32'(bus.clr_done), 32'h1);
    chk("t3_rst_off", 32'(bus.lat_rst), 32'h0);
    for (int e = 0; e < int'(NE); e++) chk("t3_mem_zero", 32'(entry(e)), 32'h0);
    wait_ack("t3_ack_timeout", 10, waited);
    chk("t3_ack_delay", 32'(waited), 32'd3);
    chk("t3_ack", 32'(bus.ack), 32'h2);
    bus.req = '0;
    @(negedge clk);
    chk("t3_mem2", 32'(entry(2)), 32'h5A);

    // Asynchronous reset in the middle of the enable pulse
    bus.req = 4'b0100; bus.wdata[16 +: DW] = 8'h3C; bus.waddr[6 +: AW] = 3'd1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (bus.lat_en == '0 && cnt < 6);
    chk("t4_pulse_en", 32'(bus.lat_en), 32'h02);
    #1 reset = 1'b1; bus.req = '0;
    #1 chk("t4_async_en", 32'(bus.lat_en), 32'h0);
    chk("t4_async_busy", 32'(bus.busy), 32'h0);
    #1 reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ack != '0) cnt++;
    end
    chk("t4_no_ack", 32'(cnt), 32'd0);

    // Asynchronous reset in the middle of a clear sweep
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    chk("t4b_rst0", 32'(bus.lat_rst), 32'h01);
    repeat (2) @(negedge clk);
    chk("t4b_rst2", 32'(bus.lat_rst), 32'h04);
    #1 reset = 1'b1;
    #1 chk("t4b_async_rst", 32'(bus.lat_rst), 32'h0);
    #1 reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.clr_done) cnt++;
    end
    chk("t4b_no_done", 32'(cnt), 32'd0);

    // Clear requested during HOLD, plus an ignored clear mid-sweep
    bus.req = 4'b1000; bus.wdata[24 +: DW] = 8'hC3; bus.waddr[9 +: AW] = 3'd0;
    wait_ack("t5_ack1_timeout", 8, waited);
    chk("t5_ack1", 32'(bus.ack), 32'h8);
    bus.clr_req = 1'b1;
    first_rst = -1; done_c = -1; ack_c = -1;
    for (int c = 1; c <= 20 && ack_c < 0; c++) begin
      @(negedge clk);
      bus.clr_req = (c == 5);
      if (bus.lat_rst != '0 && first_rst < 0) first_rst = c;
      if (bus.clr_done) done_c = c;
      if (bus.ack != '0) begin ack_c = c; bus.req = '0; end
    end
    bus.clr_req = 1'b0;
    chk("t5_first_rst", 32'(first_rst), 32'd2);
    chk("t5_done", 32'(done_c), 32'd10);
    chk("t5_ack2", 32'(ack_c), 32'd13);
    @(negedge clk);
    chk("t5_mem0", 32'(entry(0)), 32'hC3);
    chk("t5_mem7", 32'(entry(7)), 32'h0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
